// File: rtl/iomem_pkg.sv
// rtl/iomem_pkg.sv - shared types and iomem address map constants for iomem agents
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } iomem_state_e;

  // Region select lives in addr[31:24]
  localparam logic [7:0] REGION_GPIO  = 8'h03;
  localparam logic [7:0] REGION_MMIO  = 8'h06;
  localparam logic [7:0] REGION_RAVEN = 8'h07;
  localparam logic [7:0] REGION_MINE  = 8'h08;
  localparam logic [7:0] REGION_LED1  = 8'h09;

  localparam logic [7:0] RAVEN_OFS_DATA = 8'h00;
  localparam logic [7:0] RAVEN_OFS_OE   = 8'h04;
  localparam logic [7:0] RAVEN_OFS_PU   = 8'h08;
  localparam logic [7:0] RAVEN_OFS_PD   = 8'h0c;

  function automatic logic [7:0] region_of(input logic [31:0] addr);
    return addr[31:24];
  endfunction

endpackage

// File: rtl/iomem_watchdog.sv
// rtl/iomem_watchdog.sv - loadable/clearable cycle counter with enable and expiry pulse
module iomem_watchdog #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Pulses during the limit-th enabled cycle so the caller acts on the edge that ends it
  assign expire_o = en_i && (limit_i != '0) && (count_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/iomem_initiator.sv
// rtl/iomem_initiator.sv - single-outstanding iomem bus master with response timeout
module iomem_initiator
  import iomem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  iomem_state_e state_q;
  logic         cmd_ready_q;
  logic         rsp_valid_q;
  logic         rsp_err_q;
  logic [31:0]  rsp_rdata_q;
  logic         iomem_valid_q;
  logic [31:0]  iomem_addr_q;
  logic [31:0]  iomem_wdata_q;
  logic [3:0]   iomem_wstrb_q;
  logic         wd_expire;

  iomem_watchdog #(
    .CNT_W(CNT_W)
  ) u_watchdog (
    .clk_i      (clk),
    .resetn_i   (resetn),
    .clr_i      (state_q != ST_REQ),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (state_q == ST_REQ),
    .limit_i    (CNT_W'(TIMEOUT_CYCLES)),
    .expire_o   (wd_expire)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      iomem_valid_q <= 1'b0;
      iomem_addr_q  <= '0;
      iomem_wdata_q <= '0;
      iomem_wstrb_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            iomem_addr_q  <= cmd_addr;
            iomem_wdata_q <= cmd_wdata;
            iomem_wstrb_q <= cmd_wstrb;
            iomem_valid_q <= 1'b1;
            cmd_ready_q   <= 1'b0;
            state_q       <= ST_REQ;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_REQ: begin
          // A ready on the expiry edge still counts as a normal completion
          if (iomem_ready) begin
            rsp_rdata_q   <= iomem_rdata;
            rsp_err_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            iomem_valid_q <= 1'b0;
            state_q       <= ST_RSP;
          end else if (wd_expire) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_valid_q   <= 1'b1;
            iomem_valid_q <= 1'b0;
            state_q       <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          iomem_valid_q <= 1'b0;
          rsp_valid_q   <= 1'b0;
          cmd_ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign iomem_valid = iomem_valid_q;
  assign iomem_addr  = iomem_addr_q;
  assign iomem_wdata = iomem_wdata_q;
  assign iomem_wstrb = iomem_wstrb_q;

endmodule

// File: tb/tb_iomem_initiator.sv
// tb/tb_iomem_initiator.sv - directed scoreboard bench for iomem_initiator
module tb_iomem_initiator;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t sb_q[$];

  // Responder model: raises ready resp_delay+1 samples after valid first seen; -1 never answers
  logic        rdy_model;
  logic        late_pulse;
  logic [31:0] mem [16];
  int          resp_delay;
  int          wait_cnt;
  int          vcnt;

  assign iomem_ready = rdy_model | late_pulse;

  iomem_initiator #(
    .TIMEOUT_CYCLES(16),
    .CNT_W(8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (iomem_valid === 1'b1) vcnt++;
  end

  always begin
    @(posedge clk);
    #1;
    if (!resetn || !iomem_valid || rdy_model) begin
      rdy_model = 1'b0;
      wait_cnt  = 0;
    end else begin
      wait_cnt++;
      if (wait_cnt == resp_delay + 1) begin
        rdy_model = 1'b1;
        if (iomem_wstrb == 4'b0000) begin
          iomem_rdata = mem[iomem_addr[27:24]];
        end else begin
          iomem_rdata = 32'h0;
          for (int b = 0; b < 4; b++)
            if (iomem_wstrb[b]) mem[iomem_addr[27:24]][8*b +: 8] = iomem_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input logic [31:0] exp_rdata, input logic exp_err, input bit push,
                      output int vstart);
    rsp_t e;
    bit ok;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    if (push) sb_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wstrb = ws;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("cmd_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    vstart = vcnt;
  endtask

  task automatic get_rsp(input int hold);
    rsp_t e;
    bit got;
    logic [31:0] r0;
    rsp_ready = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rsp_arrive", 32'(got), 32'd1);
    e = sb_q.pop_front();
    if (got) begin
      r0 = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_hold_rdata", rsp_rdata, r0);
        chk("rsp_hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_rsp_cmd_ready", 32'(cmd_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int vs;
    resetn     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    cmd_wstrb  = '0;
    rsp_ready  = 1'b0;
    rdy_model  = 1'b0;
    late_pulse = 1'b0;
    iomem_rdata = '0;
    resp_delay = 1;
    wait_cnt   = 0;
    vcnt       = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[6] = 32'h0000_0005;
    mem[7] = 32'hCAFE_BABE;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_iomem_valid", 32'(iomem_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_iomem_addr", iomem_addr, 32'd0);
    chk("rst_iomem_wdata", iomem_wdata, 32'd0);
    chk("rst_iomem_wstrb", 32'(iomem_wstrb), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // GPIO write then read-back through a 1-cycle responder
    resp_delay = 1;
    send(32'h0300_0000, 32'h0000_00C0, 4'b0001, 32'h0, 1'b0, 1'b1, vs);
    chk("gpio_wr_req_fields", iomem_addr, 32'h0300_0000);
    get_rsp(0);
    chk("gpio_wr_valid_cycles", 32'(vcnt - vs), 32'd2);
    send(32'h0300_0000, 32'h0, 4'b0000, 32'h0000_00C0, 1'b0, 1'b1, vs);
    get_rsp(0);
    chk("gpio_rd_valid_cycles", 32'(vcnt - vs), 32'd2);

    // MMIO read with 5 cycles of response backpressure
    send(32'h0600_0000, 32'h0, 4'b0000, 32'h0000_0005, 1'b0, 1'b1, vs);
    get_rsp(5);

    // Timeout against a silent responder, then a stray late ready
    resp_delay = -1;
    send(32'h0A00_0000, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b1, vs);
    get_rsp(0);
    chk("timeout_valid_cycles", 32'(vcnt - vs), 32'd16);
    repeat (3) @(posedge clk);
    #1;
    late_pulse = 1'b1;
    @(posedge clk);
    #1;
    late_pulse = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_ready_no_rsp", 32'(rsp_valid), 32'd0);
      chk("late_ready_idle", 32'(cmd_ready), 32'd1);
    end

    // Ready raised in the 16th REQ cycle wins over expiry
    resp_delay = 15;
    send(32'h0700_0000, 32'h0, 4'b0000, 32'hCAFE_BABE, 1'b0, 1'b1, vs);
    get_rsp(0);
    chk("boundary_valid_cycles", 32'(vcnt - vs), 32'd16);

    // Reset two cycles into REQ discards the transaction
    resp_delay = -1;
    send(32'h0300_0000, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b0, vs);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(iomem_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_reset_valid", 32'(iomem_valid), 32'd0);
    chk("async_reset_rsp", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("after_reset_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("after_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    resp_delay = 1;
    send(32'h0300_0000, 32'h0, 4'b0000, 32'h0000_00C0, 1'b0, 1'b1, vs);
    get_rsp(0);

    // Request fields held while cmd_* toggle during a 7-cycle responder wait
    resp_delay = 7;
    send(32'h0800_0004, 32'h1234_5678, 4'b1111, 32'h0, 1'b0, 1'b1, vs);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (iomem_valid !== 1'b1) break;
      chk("held_addr", iomem_addr, 32'h0800_0004);
      chk("held_wdata", iomem_wdata, 32'h1234_5678);
      chk("held_wstrb", 32'(iomem_wstrb), 32'hF);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_wstrb = 4'($urandom);
    end
    cmd_valid = 1'b0;
    chk("held_valid_cycles", 32'(vcnt - vs), 32'd8);
    get_rsp(0);
    resp_delay = 1;
    send(32'h0800_0004, 32'h0, 4'b0000, 32'h1234_5678, 1'b0, 1'b1, vs);
    get_rsp(2);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
